// File: rtl/multicycle_control_if.sv
// Control <-> datapath bundle for the multicycle RV32I core.
// master: the control unit (consumes instruction fields and ALU flags,
//         drives mux selects, write strobes, ALU op, retire/instret).
// slave : the datapath side (drives instruction fields and flags).
interface multicycle_control_if #(
  parameter int RET_W = 32
);
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic             zero;
  logic             sign;
  logic             pcWrite;
  logic             adrSrc;
  logic             memWrite;
  logic             irWrite;
  logic             regWrite;
  logic [1:0]       resultSrc;
  logic [1:0]       aluSrcA;
  logic [1:0]       aluSrcB;
  logic [1:0]       immSrc;
  logic [2:0]       aluControl;
  logic             retire;
  logic [RET_W-1:0] instret;

  modport master (
    input  op, funct3, funct7b5, zero, sign,
    output pcWrite, adrSrc, memWrite, irWrite, regWrite, resultSrc,
           aluSrcA, aluSrcB, immSrc, aluControl, retire, instret
  );

  modport slave (
    output op, funct3, funct7b5, zero, sign,
    input  pcWrite, adrSrc, memWrite, irWrite, regWrite, resultSrc,
           aluSrcA, aluSrcB, immSrc, aluControl, retire, instret
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle control unit for the RV32I core: sequences fetch, decode,
// execute, memory and writeback, drives the ALU op and datapath selects,
// resolves branches from ALU zero/sign, and counts retired instructions.
// Ports:
//   clk  - clock, all state updates on rising edge
//   rst  - synchronous active-high reset
//   bus  - multicycle_control_if.master (instruction fields, ALU flags in;
//          selects, strobes, aluControl, retire, instret out)
module multicycle_control #(
  parameter int RET_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_control_if.master  bus
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b010;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL
  } state_t;

  state_t           r_state;
  state_t           w_next;
  state_t           w_cur;
  logic             w_retire;
  logic [2:0]       w_funct_op;
  logic             w_taken;
  logic [RET_W-1:0] r_instret;

  // funct3-driven ALU op for EXECR/EXECI; bit 30 only selects SUB for R-type
  always_comb begin
    w_funct_op = 3'b011;
    case (bus.funct3)
      3'b000:  w_funct_op = (bus.op == OP_R && bus.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  w_funct_op = 3'b001;
      3'b100:  w_funct_op = 3'b100;
      3'b101:  w_funct_op = 3'b101;
      3'b110:  w_funct_op = 3'b110;
      3'b111:  w_funct_op = 3'b111;
      default: w_funct_op = 3'b011;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (bus.funct3)
      3'b000:  w_taken = bus.zero;
      3'b001:  w_taken = !bus.zero;
      3'b100:  w_taken = bus.sign;
      3'b101:  w_taken = !bus.sign;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instret <= r_instret + RET_W'(1);
    end
  end

  // In reset the outputs show FETCH decode, with strobes masked below.
  assign w_cur       = rst ? FETCH : r_state;
  assign bus.instret = r_instret;
  assign bus.retire  = w_retire;

  always_comb begin
    bus.immSrc = 2'b00;
    case (bus.op)
      OP_SW:   bus.immSrc = 2'b01;
      OP_BR:   bus.immSrc = 2'b10;
      OP_JAL:  bus.immSrc = 2'b11;
      default: bus.immSrc = 2'b00;
    endcase
  end

  always_comb begin
    w_next         = FETCH;
    bus.pcWrite    = 1'b0;
    bus.adrSrc     = 1'b0;
    bus.memWrite   = 1'b0;
    bus.irWrite    = 1'b0;
    bus.regWrite   = 1'b0;
    bus.resultSrc  = 2'b00;
    bus.aluSrcA    = 2'b00;
    bus.aluSrcB    = 2'b00;
    bus.aluControl = ALU_ADD;
    w_retire       = 1'b0;
    case (w_cur)
      FETCH: begin
        bus.irWrite   = 1'b1;
        bus.aluSrcB   = 2'b10;
        bus.resultSrc = 2'b10;
        bus.pcWrite   = 1'b1;
        w_next        = DECODE;
      end
      DECODE: begin
        // precompute branch/jump target into ALUOut
        bus.aluSrcA = 2'b01;
        bus.aluSrcB = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_R:         w_next = EXECR;
          OP_I:         w_next = EXECI;
          OP_BR:        w_next = BRANCH;
          OP_JAL:       w_next = JAL;
          default:      w_next = FETCH;
        endcase
      end
      MEMADR: begin
        bus.aluSrcA = 2'b10;
        bus.aluSrcB = 2'b01;
        w_next      = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        bus.adrSrc = 1'b1;
        w_next     = MEMWB;
      end
      MEMWB: begin
        bus.resultSrc = 2'b01;
        bus.regWrite  = 1'b1;
        w_retire      = 1'b1;
      end
      MEMWRITE: begin
        bus.adrSrc   = 1'b1;
        bus.memWrite = 1'b1;
        w_retire     = 1'b1;
      end
      EXECR: begin
        bus.aluSrcA    = 2'b10;
        bus.aluControl = w_funct_op;
        w_next         = ALUWB;
      end
      EXECI: begin
        bus.aluSrcA    = 2'b10;
        bus.aluSrcB    = 2'b01;
        bus.aluControl = w_funct_op;
        w_next         = ALUWB;
      end
      ALUWB: begin
        bus.regWrite = 1'b1;
        w_retire     = 1'b1;
      end
      BRANCH: begin
        bus.aluSrcA    = 2'b10;
        bus.aluControl = ALU_SUB;
        bus.pcWrite    = w_taken;
        w_retire       = 1'b1;
      end
      JAL: begin
        // ALUOut already holds the target; ALU computes PC+4 for rd
        bus.aluSrcA = 2'b01;
        bus.aluSrcB = 2'b10;
        bus.pcWrite = 1'b1;
        w_next      = ALUWB;
      end
      default: w_next = FETCH;
    endcase
    if (rst) begin
      bus.pcWrite  = 1'b0;
      bus.irWrite  = 1'b0;
      bus.memWrite = 1'b0;
      bus.regWrite = 1'b0;
      w_retire     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Uses a narrow instret so the
// counter wraps during the random back-to-back run.
module tb_multicycle_control;
  localparam int RW = 4;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;

  typedef struct packed {
    logic       pcWrite, adrSrc, memWrite, irWrite, regWrite;
    logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
    logic [2:0] aluControl;
    logic       retire;
  } ctl_t;

  logic clk, rst;
  multicycle_control_if #(.RET_W(RW)) bus ();
  multicycle_control #(.RET_W(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] m_ret = '0;
  ctl_t          obs [0:7];
  logic [RW-1:0] obs_ret;
  int            obs_n;

  function automatic ctl_t cur_out();
    ctl_t o;
    o = '{bus.pcWrite, bus.adrSrc, bus.memWrite, bus.irWrite, bus.regWrite,
          bus.resultSrc, bus.aluSrcA, bus.aluSrcB, bus.immSrc, bus.aluControl,
          bus.retire};
    return o;
  endfunction

  // ---- reference model: per-instruction latency and per-cycle controls ----
  function automatic int lat_of(logic [6:0] op);
    case (op)
      LW: return 5;
      SW, RT, IT, JL: return 4;
      BR: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(logic [6:0] op, logic [2:0] f3, logic f7);
    case (f3)
      3'd0: return (op == RT && f7) ? 3'b010 : 3'b000;
      3'd1, 3'd4, 3'd5, 3'd6, 3'd7: return f3;
      default: return 3'b011;
    endcase
  endfunction

  function automatic logic taken_of(logic [2:0] f3, logic z, logic s);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return s;
      3'd5: return !s;
      default: return 1'b0;
    endcase
  endfunction

  function automatic ctl_t exp_vec(logic [6:0] op, logic [2:0] f3, logic f7,
                                   logic z, logic s, int c);
    ctl_t e = '0;
    e.immSrc = (op == SW) ? 2'd1 : (op == BR) ? 2'd2 : (op == JL) ? 2'd3 : 2'd0;
    if (c == 0) begin
      e.pcWrite = 1; e.irWrite = 1; e.aluSrcB = 2; e.resultSrc = 2;
    end else if (c == 1) begin
      e.aluSrcA = 1; e.aluSrcB = 1;
    end else begin
      case (op)
        LW: if (c == 2) begin e.aluSrcA = 2; e.aluSrcB = 1; end
            else if (c == 3) e.adrSrc = 1;
            else begin e.resultSrc = 1; e.regWrite = 1; e.retire = 1; end
        SW: if (c == 2) begin e.aluSrcA = 2; e.aluSrcB = 1; end
            else begin e.adrSrc = 1; e.memWrite = 1; e.retire = 1; end
        RT, IT: if (c == 2) begin
              e.aluSrcA = 2; e.aluSrcB = (op == IT) ? 2'd1 : 2'd0;
              e.aluControl = alu_of(op, f3, f7);
            end else begin e.regWrite = 1; e.retire = 1; end
        BR: begin
              e.aluSrcA = 2; e.aluControl = 3'b010;
              e.pcWrite = taken_of(f3, z, s); e.retire = 1;
            end
        JL: if (c == 2) begin e.aluSrcA = 1; e.aluSrcB = 2; e.pcWrite = 1; end
            else begin e.regWrite = 1; e.retire = 1; end
        default: ;
      endcase
    end
    return e;
  endfunction

  // Drives one instruction and records n cycles of outputs (no checking).
  task automatic capture(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z, input logic s, input int n);
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z; bus.sign = s;
    obs_n = n;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      obs[c] = cur_out();
      if (c == 0) obs_ret = bus.instret;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    ctl_t e;
    rst = 1'b1;
    bus.op = LW; bus.funct3 = 0; bus.funct7b5 = 0; bus.zero = 0; bus.sign = 0;
    e = exp_vec(LW, 0, 0, 0, 0, 0);
    e.pcWrite = 0; e.irWrite = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (cur_out() !== e) begin
        errors++; $display("FAIL reset_outs got %h want %h", cur_out(), e);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cur_out() !== exp_vec(LW, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL reset_fetch got %h want %h", cur_out(), exp_vec(LW, 0, 0, 0, 0, 0));
    end
    checks++;
    if (bus.instret !== '0) begin
      errors++; $display("FAIL reset_instret got %0d want 0", bus.instret);
    end
    // back to a clean FETCH boundary
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_lw();
    capture(LW, 3'd2, 1'b0, 1'b0, 1'b0, 5);
    for (int c = 0; c < obs_n; c++) begin
      checks++;
      if (obs[c] !== exp_vec(LW, 3'd2, 0, 0, 0, c)) begin
        errors++; $display("FAIL lw c%0d got %h want %h", c, obs[c], exp_vec(LW, 3'd2, 0, 0, 0, c));
      end
    end
    checks++;
    if (obs_ret !== m_ret) begin errors++; $display("FAIL lw_instret got %0d want %0d", obs_ret, m_ret); end
    m_ret++;
  endtask

  task automatic test_alu_decode();
    logic [2:0] f3s [0:7] = '{3'd0, 3'd0, 3'd1, 3'd5, 3'd4, 3'd6, 3'd7, 3'd3};
    for (int k = 0; k < 16; k++) begin
      logic [6:0] op = (k % 2 == 0) ? RT : IT;
      logic [2:0] f3 = f3s[k / 2];
      logic       f7 = (k < 4) ? 1'b1 : 1'($urandom_range(1));
      capture(op, f3, f7, 1'b0, 1'b0, 4);
      for (int c = 0; c < obs_n; c++) begin
        checks++;
        if (obs[c] !== exp_vec(op, f3, f7, 0, 0, c)) begin
          errors++; $display("FAIL alu op%b f3=%0d f7=%0d c%0d got %h want %h",
                             op, f3, f7, c, obs[c], exp_vec(op, f3, f7, 0, 0, c));
        end
      end
      checks++;
      if (obs_ret !== m_ret) begin errors++; $display("FAIL alu_instret got %0d want %0d", obs_ret, m_ret); end
      m_ret++;
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3s [0:7] = '{3'd0, 3'd0, 3'd4, 3'd5, 3'd2, 3'd1, 3'd1, 3'd5};
    logic [1:0] zs  [0:7] = '{2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b00, 2'b00};
    for (int k = 0; k < 8; k++) begin
      logic z = zs[k][1], s = zs[k][0];
      capture(BR, f3s[k], 1'b0, z, s, 3);
      for (int c = 0; c < obs_n; c++) begin
        checks++;
        if (obs[c] !== exp_vec(BR, f3s[k], 0, z, s, c)) begin
          errors++; $display("FAIL branch f3=%0d z=%0d s=%0d c%0d got %h want %h",
                             f3s[k], z, s, c, obs[c], exp_vec(BR, f3s[k], 0, z, s, c));
        end
      end
      checks++;
      if (obs_ret !== m_ret) begin errors++; $display("FAIL br_instret got %0d want %0d", obs_ret, m_ret); end
      m_ret++;
    end
  endtask

  task automatic test_jal_illegal();
    logic [6:0] ops [0:3] = '{JL, 7'b0000000, SW, 7'b1111111};
    for (int k = 0; k < 4; k++) begin
      capture(ops[k], 3'd0, 1'b0, 1'b1, 1'b1, lat_of(ops[k]));
      for (int c = 0; c < obs_n; c++) begin
        checks++;
        if (obs[c] !== exp_vec(ops[k], 0, 0, 1, 1, c)) begin
          errors++; $display("FAIL jal_ill op%b c%0d got %h want %h",
                             ops[k], c, obs[c], exp_vec(ops[k], 0, 0, 1, 1, c));
        end
      end
      checks++;
      if (obs_ret !== m_ret) begin errors++; $display("FAIL jal_ill_instret got %0d want %0d", obs_ret, m_ret); end
      if (lat_of(ops[k]) > 2) m_ret++;
    end
  endtask

  // reset lands in MEMWRITE, where memWrite/retire would otherwise fire
  task automatic test_abort();
    ctl_t e;
    capture(SW, 3'd2, 1'b0, 1'b0, 1'b0, 3);
    for (int c = 0; c < obs_n; c++) begin
      checks++;
      if (obs[c] !== exp_vec(SW, 3'd2, 0, 0, 0, c)) begin
        errors++; $display("FAIL abort_pre c%0d got %h want %h", c, obs[c], exp_vec(SW, 3'd2, 0, 0, 0, c));
      end
    end
    rst = 1'b1;
    e = exp_vec(SW, 3'd2, 0, 0, 0, 0);
    e.pcWrite = 0; e.irWrite = 0;
    @(negedge clk);
    checks++;
    if (cur_out() !== e) begin errors++; $display("FAIL abort_outs got %h want %h", cur_out(), e); end
    checks++;
    if (bus.instret !== m_ret) begin errors++; $display("FAIL abort_instret got %0d want %0d", bus.instret, m_ret); end
    @(posedge clk); #1;
    rst = 1'b0;
    m_ret = '0;
  endtask

  task automatic test_back_to_back();
    logic [6:0] pool [0:7] = '{LW, SW, RT, IT, BR, JL, 7'b0000000, 7'b0110111};
    for (int k = 0; k < 60; k++) begin
      logic [6:0] op = pool[$urandom_range(7)];
      logic [2:0] f3 = 3'($urandom_range(7));
      logic f7 = 1'($urandom_range(1)), z = 1'($urandom_range(1)), s = 1'($urandom_range(1));
      capture(op, f3, f7, z, s, lat_of(op));
      for (int c = 0; c < obs_n; c++) begin
        checks++;
        if (obs[c] !== exp_vec(op, f3, f7, z, s, c)) begin
          errors++; $display("FAIL b2b k%0d op%b f3=%0d c%0d got %h want %h",
                             k, op, f3, c, obs[c], exp_vec(op, f3, f7, z, s, c));
        end
      end
      checks++;
      if (obs_ret !== m_ret) begin errors++; $display("FAIL b2b_instret k%0d got %0d want %0d", k, obs_ret, m_ret); end
      if (lat_of(op) > 2) m_ret++;
    end
    @(negedge clk);
    checks++;
    if (bus.instret !== m_ret) begin errors++; $display("FAIL final_instret got %0d want %0d", bus.instret, m_ret); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_alu_decode();
    test_branch();
    test_jal_illegal();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
